store_align_unit: RTL and testbench

- Registered, parametrised successor to the combinational write-enable aligner. Sits between the EX/MEM store path and the data-memory/MMIO write port.
- Converts a store request into byte-lane write enables and shifted write data, using the access size and the address offset.
- Splits a store that crosses the data-word boundary into two aligned bus beats. Uses a valid/ready handshake on both sides.
- Flags illegal misaligned stores when splitting is disabled.

---
 rtl/store_align_pkg.sv | 23 ++
 rtl/store_align_lane_shifter.sv | 24 ++
 rtl/store_align_unit.sv | 116 +++++++++++
 tb/tb_store_align_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/store_align_pkg.sv
// Shared encodings and lane-mask helper for the store alignment path.
// Purely declarative: no latency, no flow control of its own.
package store_align_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} state_e;

   // Two-word-wide byte mask; sized for the largest supported bus (64-bit).
   function automatic logic [15:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] off,
                                             input int         bytes);
      logic [15:0] ones;
      logic [2:0]  o;
      ones = (16'd1 << (4'd1 << size)) - 16'd1;
      o    = off & 3'(bytes - 1);
      return ones << o;
   endfunction

endpackage

// File: rtl/store_align_lane_shifter.sv
// Combinational byte-lane mask/data formation over a two-word window.
// Zero latency; no handshake, the caller owns flow control.
module lane_shifter
   import store_align_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int BYTES = DATA_W / 8,
   localparam int OFF_W = $clog2(BYTES)
) (
   input  logic [OFF_W-1:0]    off_i,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [1:0]          size_i,
   output logic [2*BYTES-1:0]  mask_o,
   output logic [2*DATA_W-1:0] wdata_o,
   output logic                split_o,
   output logic                too_wide_o
);

   assign mask_o     = (2*BYTES)'(lane_mask(size_i, 3'(off_i), BYTES));
   assign wdata_o    = {{DATA_W{1'b0}}, data_i} << {off_i, 3'b000};
   assign split_o    = |mask_o[2*BYTES-1:BYTES];
   assign too_wide_o = (32'd1 << size_i) > 32'(BYTES);

endmodule

// File: rtl/store_align_unit.sv
// Store aligner: request accepted at t is presented as beat0 at t+1; crossing stores take two beats.
// Beats hold stable while mem_ready is low; req_ready drops whenever the current beat cannot retire.
module store_align_unit
   import store_align_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int SPLIT_EN  = 1,
   parameter int ERR_CNT_W = 8,
   localparam int BYTES    = DATA_W / 8,
   localparam int OFF_W    = $clog2(BYTES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DATA_W-1:0]    req_data,
   input  logic [1:0]           req_size,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic [BYTES-1:0]     mem_wen,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_e                 state_q;
   logic                   split_q;
   logic [ADDR_W-1:0]      mem_addr_q, hi_addr_q;
   logic [DATA_W-1:0]      mem_wdata_q, hi_wdata_q;
   logic [BYTES-1:0]       mem_wen_q, hi_wen_q;
   logic                   err_pulse_q;
   logic [ERR_CNT_W-1:0]   err_count_q;

   logic [2*BYTES-1:0]     wide_mask;
   logic [2*DATA_W-1:0]    wide_data;
   logic                   split, too_wide, bad, accept, take;
   logic [ADDR_W-1:0]      lo_addr_d, hi_addr_d;

   lane_shifter #(.DATA_W(DATA_W)) u_shift (
      .off_i      (req_addr[OFF_W-1:0]),
      .data_i     (req_data),
      .size_i     (req_size),
      .mask_o     (wide_mask),
      .wdata_o    (wide_data),
      .split_o    (split),
      .too_wide_o (too_wide)
   );

   assign lo_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign hi_addr_d = lo_addr_d + ADDR_W'(BYTES);
   assign bad       = too_wide | (split & (SPLIT_EN == 0));

   assign req_ready = (state_q == ST_IDLE)
                    | ((state_q == ST_LO) & mem_ready & ~split_q)
                    | ((state_q == ST_HI) & mem_ready);
   assign accept    = req_valid & req_ready;
   assign take      = accept & ~bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         split_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wen_q   <= '0;
         hi_addr_q   <= '0;
         hi_wdata_q  <= '0;
         hi_wen_q    <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_pulse_q <= accept & bad;
         if (accept & bad & ~&err_count_q)
            err_count_q <= err_count_q + ERR_CNT_W'(1);

         // take implies the current beat (if any) retires this cycle
         if (take) begin
            state_q     <= ST_LO;
            mem_addr_q  <= lo_addr_d;
            mem_wen_q   <= wide_mask[BYTES-1:0];
            mem_wdata_q <= wide_data[DATA_W-1:0];
            hi_addr_q   <= hi_addr_d;
            hi_wen_q    <= wide_mask[2*BYTES-1:BYTES];
            hi_wdata_q  <= wide_data[2*DATA_W-1:DATA_W];
            split_q     <= split;
         end else if (mem_ready) begin
            unique case (state_q)
               ST_LO: begin
                  if (split_q) begin
                     state_q     <= ST_HI;
                     mem_addr_q  <= hi_addr_q;
                     mem_wen_q   <= hi_wen_q;
                     mem_wdata_q <= hi_wdata_q;
                     split_q     <= 1'b0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_HI:   state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign mem_valid = (state_q != ST_IDLE);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wen   = mem_wen_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit (32-bit bus), split-enabled and split-disabled instances.
module tb_store_align_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_valid_ns = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_size = '0;
   logic        mem_ready = 1'b1;

   logic        req_ready, mem_valid, err_pulse;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wen;
   logic [7:0]  err_count;

   logic        req_ready_ns, mem_valid_ns, err_pulse_ns;
   logic [31:0] mem_addr_ns, mem_wdata_ns;
   logic [3:0]  mem_wen_ns;
   logic [7:0]  err_count_ns;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wen(mem_wen), .err_pulse(err_pulse), .err_count(err_count)
   );

   store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0), .ERR_CNT_W(8)) dut_ns (
      .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .mem_valid(mem_valid_ns), .mem_ready(mem_ready), .mem_addr(mem_addr_ns),
      .mem_wdata(mem_wdata_ns), .mem_wen(mem_wen_ns), .err_pulse(err_pulse_ns), .err_count(err_count_ns)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      req_addr = a;
      req_data = d;
      req_size = s;
   endtask

   task automatic test_reset();
      #1;
      total_cnt++; if (mem_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", mem_valid); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else pass_cnt++;
      total_cnt++; if ({mem_addr, mem_wdata, mem_wen} !== 68'h0) $display("FAIL rst_beat got %h/%h/%b exp 0", mem_addr, mem_wdata, mem_wen); else pass_cnt++;
      total_cnt++; if ({err_pulse, err_count} !== 9'h0) $display("FAIL rst_err got %b/%0d exp 0/0", err_pulse, err_count); else pass_cnt++;
      tick();
      rst = 1'b0;
      tick();
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready got %b exp 1", req_ready); else pass_cnt++;
   endtask

   task automatic test_byte();
      mem_ready = 1'b1;
      drive(32'h1223_4573, 32'h0000_0055, 2'd0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      total_cnt++; if (mem_valid !== 1'b1) $display("FAIL sb_valid got %b exp 1", mem_valid); else pass_cnt++;
      total_cnt++; if (mem_addr !== 32'h1223_4570) $display("FAIL sb_addr got %h exp 12234570", mem_addr); else pass_cnt++;
      total_cnt++; if (mem_wen !== 4'b1000) $display("FAIL sb_wen got %b exp 1000", mem_wen); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 32'h5500_0000) $display("FAIL sb_wdata got %h exp 55000000", mem_wdata); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL sb_ready got %b exp 1", req_ready); else pass_cnt++;
      tick();
      total_cnt++; if (mem_valid !== 1'b0) $display("FAIL sb_done got %b exp 0", mem_valid); else pass_cnt++;
   endtask

   task automatic test_split();
      mem_ready = 1'b1;
      drive(32'h1000_0002, 32'hAABB_CCDD, 2'd2);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      total_cnt++; if ({mem_valid, mem_addr} !== {1'b1, 32'h1000_0000}) $display("FAIL sw0_addr got %b/%h exp 1/10000000", mem_valid, mem_addr); else pass_cnt++;
      total_cnt++; if (mem_wen !== 4'b1100) $display("FAIL sw0_wen got %b exp 1100", mem_wen); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 32'hCCDD_0000) $display("FAIL sw0_wdata got %h exp ccdd0000", mem_wdata); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL sw0_ready got %b exp 0", req_ready); else pass_cnt++;
      tick();
      total_cnt++; if ({mem_valid, mem_addr} !== {1'b1, 32'h1000_0004}) $display("FAIL sw1_addr got %b/%h exp 1/10000004", mem_valid, mem_addr); else pass_cnt++;
      total_cnt++; if (mem_wen !== 4'b0011) $display("FAIL sw1_wen got %b exp 0011", mem_wen); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 32'h0000_AABB) $display("FAIL sw1_wdata got %h exp 0000aabb", mem_wdata); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL sw1_ready got %b exp 1", req_ready); else pass_cnt++;
      tick();
      total_cnt++; if (mem_valid !== 1'b0) $display("FAIL sw_done got %b exp 0", mem_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [3];
      logic [31:0] datas [3];
      addrs = '{32'h0, 32'h4, 32'h8};
      datas = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      mem_ready = 1'b1;
      req_valid = 1'b1;
      drive(addrs[0], datas[0], 2'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i < 2) drive(addrs[i+1], datas[i+1], 2'd2);
         else req_valid = 1'b0;
         total_cnt++; if ({mem_valid, mem_addr, mem_wen} !== {1'b1, addrs[i], 4'b1111}) $display("FAIL b2b_beat%0d got %b/%h/%b exp 1/%h/1111", i, mem_valid, mem_addr, mem_wen, addrs[i]); else pass_cnt++;
         total_cnt++; if (mem_wdata !== datas[i]) $display("FAIL b2b_wdata%0d got %h exp %h", i, mem_wdata, datas[i]); else pass_cnt++;
      end
      tick();
      total_cnt++; if (mem_valid !== 1'b0) $display("FAIL b2b_done got %b exp 0", mem_valid); else pass_cnt++;
   endtask

   task automatic test_stall();
      mem_ready = 1'b0;
      drive(32'h2000_0003, 32'h0123_4567, 2'd2);
      req_valid = 1'b1;
      tick();
      drive(32'h3000_0000, 32'hDEAD_BEEF, 2'd2);
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if ({mem_valid, mem_addr, mem_wen, mem_wdata} !== {1'b1, 32'h2000_0000, 4'b1000, 32'h6700_0000})
            $display("FAIL stall_beat%0d got %b/%h/%b/%h exp 1/20000000/1000/67000000", i, mem_valid, mem_addr, mem_wen, mem_wdata); else pass_cnt++;
         total_cnt++; if (req_ready !== 1'b0) $display("FAIL stall_ready%0d got %b exp 0", i, req_ready); else pass_cnt++;
         tick();
      end
      mem_ready = 1'b1;
      #1;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL stall_rel_ready got %b exp 0", req_ready); else pass_cnt++;
      tick();
      total_cnt++; if ({mem_addr, mem_wen, mem_wdata} !== {32'h2000_0004, 4'b0111, 32'h0001_2345})
         $display("FAIL stall_beat1 got %h/%b/%h exp 20000004/0111/00012345", mem_addr, mem_wen, mem_wdata); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL stall_hi_ready got %b exp 1", req_ready); else pass_cnt++;
      tick();
      req_valid = 1'b0;
      total_cnt++; if ({mem_valid, mem_addr, mem_wen, mem_wdata} !== {1'b1, 32'h3000_0000, 4'b1111, 32'hDEAD_BEEF})
         $display("FAIL stall_next got %b/%h/%b/%h exp 1/30000000/1111/deadbeef", mem_valid, mem_addr, mem_wen, mem_wdata); else pass_cnt++;
      tick();
      total_cnt++; if (mem_valid !== 1'b0) $display("FAIL stall_done got %b exp 0", mem_valid); else pass_cnt++;
   endtask

   task automatic test_reject();
      mem_ready = 1'b1;
      drive(32'h0000_0003, 32'h0000_BEEF, 2'd1);
      req_valid_ns = 1'b1;
      total_cnt++; if (req_ready_ns !== 1'b1) $display("FAIL rej_ready got %b exp 1", req_ready_ns); else pass_cnt++;
      tick();
      req_valid_ns = 1'b0;
      total_cnt++; if ({mem_valid_ns, err_pulse_ns} !== 2'b01) $display("FAIL rej_sh valid/pulse got %b/%b exp 0/1", mem_valid_ns, err_pulse_ns); else pass_cnt++;
      total_cnt++; if (err_count_ns !== 8'd1) $display("FAIL rej_sh_count got %0d exp 1", err_count_ns); else pass_cnt++;
      tick();
      total_cnt++; if ({mem_valid_ns, err_pulse_ns, err_count_ns} !== {2'b00, 8'd1}) $display("FAIL rej_after got %b/%b/%0d exp 0/0/1", mem_valid_ns, err_pulse_ns, err_count_ns); else pass_cnt++;
      drive(32'h0000_0000, 32'h1234_5678, 2'd3);
      req_valid_ns = 1'b1;
      req_valid = 1'b1;
      tick();
      req_valid_ns = 1'b0;
      req_valid = 1'b0;
      total_cnt++; if ({mem_valid_ns, err_pulse_ns, err_count_ns} !== {2'b01, 8'd2}) $display("FAIL rej_sd_ns got %b/%b/%0d exp 0/1/2", mem_valid_ns, err_pulse_ns, err_count_ns); else pass_cnt++;
      total_cnt++; if ({mem_valid, err_pulse, err_count} !== {2'b01, 8'd1}) $display("FAIL rej_sd got %b/%b/%0d exp 0/1/1", mem_valid, err_pulse, err_count); else pass_cnt++;
   endtask

   task automatic test_reject_drain();
      mem_ready = 1'b1;
      drive(32'h0000_0040, 32'hCAFE_F00D, 2'd2);
      req_valid = 1'b1;
      tick();
      total_cnt++; if ({mem_valid, mem_addr} !== {1'b1, 32'h0000_0040}) $display("FAIL drain_beat got %b/%h exp 1/00000040", mem_valid, mem_addr); else pass_cnt++;
      drive(32'h0000_0044, 32'h0, 2'd3);
      tick();
      req_valid = 1'b0;
      total_cnt++; if ({mem_valid, err_pulse, err_count} !== {2'b01, 8'd2}) $display("FAIL drain_rej got %b/%b/%0d exp 0/1/2", mem_valid, err_pulse, err_count); else pass_cnt++;
      tick();
      total_cnt++; if ({mem_valid, err_pulse} !== 2'b00) $display("FAIL drain_after got %b/%b exp 0/0", mem_valid, err_pulse); else pass_cnt++;
   endtask

   task automatic test_reset_hi();
      mem_ready = 1'b0;
      drive(32'h5000_0002, 32'h1122_3344, 2'd2);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      total_cnt++; if ({mem_valid, mem_addr} !== {1'b1, 32'h5000_0004}) $display("FAIL rhi_beat1 got %b/%h exp 1/50000004", mem_valid, mem_addr); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++; if ({mem_valid, mem_addr, mem_wen, mem_wdata} !== 69'h0) $display("FAIL rhi_async got %b/%h/%b/%h exp 0", mem_valid, mem_addr, mem_wen, mem_wdata); else pass_cnt++;
      total_cnt++; if ({err_pulse, err_count} !== 9'h0) $display("FAIL rhi_err got %b/%0d exp 0/0", err_pulse, err_count); else pass_cnt++;
      tick();
      rst = 1'b0;
      mem_ready = 1'b1;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL rhi_ready got %b exp 1", req_ready); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++; if (mem_valid !== 1'b0) $display("FAIL rhi_nobeat%0d got %b exp 0", i, mem_valid); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_byte();
      test_split();
      test_back_to_back();
      test_stall();
      test_reject();
      test_reject_drain();
      test_reset_hi();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
